hazard_control_unit: RTL and testbench

Pipeline sequencing controller for the 5-stage RISC-V core. Generates PC/IF-ID write enables, ID/EX bubble insertion, branch flushes and the data-memory request handshake. Runs a small FSM that freezes the pipeline while a multi-cycle data memory is busy. Its `id_ex_bubble` output drives the forwarding unit's `hazard_selector` input, which suppresses forwarding while a bubble is inserted.

---
 rtl/hazard_pkg.sv | 13 +
 rtl/sat_counter.sv | 20 ++
 rtl/hazard_control_unit.sv | 155 +++++++++++++++
 tb/tb_hazard_control_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM encoding and default parameter values for the
// pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned MEM_TIMEOUT_DEF = 255;
    localparam int unsigned CNT_W_DEF       = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_RUN      = 2'b00;
    localparam state_t ST_MEM_WAIT = 2'b01;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count qualifying cycles, holding at the maximum value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: stall / flush / bubble sequencing for the 5-stage
// core, with a freeze FSM for multi-cycle data memory.
// Optional feature macro: HAZARD_PERF_CNT_EN (performance counters).
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Register_Rd,
    input  logic [4:0]       IF_ID_Register_Rs1,
    input  logic [4:0]       IF_ID_Register_Rs2,
    input  logic             branch_taken,
    input  logic             EX_MEM_MemRead,
    input  logic             EX_MEM_MemWrite,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             pipe_hold,
    output logic             mem_req,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned       WC_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0]   WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    state_t          r_state;
    logic [WC_W-1:0] r_wait_cnt;
    logic            r_mem_error;

    state_t          w_next_state;
    logic [WC_W-1:0] w_wait_next;
    logic            w_set_error;
    logic            w_mem_access;
    logic            w_load_use;
    logic            w_timeout;

    assign w_mem_access = EX_MEM_MemRead | EX_MEM_MemWrite;
    assign w_load_use   = ID_EX_MemRead && (ID_EX_Register_Rd != 5'd0) &&
                          ((ID_EX_Register_Rd == IF_ID_Register_Rs1) ||
                           (ID_EX_Register_Rd == IF_ID_Register_Rs2));
    assign w_timeout    = (r_wait_cnt == WC_LAST);
    assign mem_error    = r_mem_error;

    // Mealy decode of hazard outputs and FSM next state.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        pipe_hold    = 1'b0;
        mem_req      = 1'b0;
        w_next_state = r_state;
        w_wait_next  = r_wait_cnt;
        w_set_error  = 1'b0;

        if (reset) begin
            // Reset overrides combinationally so mem_req drops asynchronously.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            w_next_state = ST_RUN;
            w_wait_next  = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    mem_req = w_mem_access;
                    if (w_mem_access && !mem_ready) begin
                        pipe_hold    = 1'b1;
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        w_next_state = ST_MEM_WAIT;
                        w_wait_next  = '0;
                    end else if (branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (w_load_use) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    mem_req = 1'b1;
                    if (!mem_ready && !w_timeout) begin
                        pipe_hold   = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        w_wait_next = r_wait_cnt + 1'b1;
                    end else begin
                        // Exit cycle: hazards held during the freeze act now.
                        w_next_state = ST_RUN;
                        w_set_error  = !mem_ready;
                        if (branch_taken) begin
                            if_id_flush = 1'b1;
                            id_ex_flush = 1'b1;
                        end else if (w_load_use) begin
                            pc_write     = 1'b0;
                            if_id_write  = 1'b0;
                            id_ex_bubble = 1'b1;
                        end
                    end
                end
                default: begin
                    w_next_state = ST_RUN;
                    w_wait_next  = '0;
                end
            endcase
        end
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_wait_cnt  <= '0;
            r_mem_error <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_next;
            if (w_set_error) begin
                r_mem_error <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!pc_write),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (if_id_flush),
        .count (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed and random checks against a cycle-level
// behavioural model of the hazard controller.
module tb_hazard_control_unit;

    localparam int unsigned T    = 4;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = 15;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          memread_ex;
    logic [4:0]    rd_ex, rs1, rs2;
    logic          br, mr, mw, rdy;
    logic          pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush;
    logic          pipe_hold, mem_req, mem_error;
    logic [CW-1:0] stall_cycles, flush_count;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    bit m_wait;
    int m_waited;
    bit m_err;
    int m_stall, m_flush;

    // Expected outputs for the current cycle
    bit e_pc, e_ifid, e_bub, e_fl, e_hold, e_req, e_frozen;

    always #5 clk = ~clk;

    hazard_control_unit #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk                (clk),
        .reset              (rst),
        .ID_EX_MemRead      (memread_ex),
        .ID_EX_Register_Rd  (rd_ex),
        .IF_ID_Register_Rs1 (rs1),
        .IF_ID_Register_Rs2 (rs2),
        .branch_taken       (br),
        .EX_MEM_MemRead     (mr),
        .EX_MEM_MemWrite    (mw),
        .mem_ready          (rdy),
        .pc_write           (pc_write),
        .if_id_write        (if_id_write),
        .id_ex_bubble       (id_ex_bubble),
        .if_id_flush        (if_id_flush),
        .id_ex_flush        (id_ex_flush),
        .pipe_hold          (pipe_hold),
        .mem_req            (mem_req),
        .mem_error          (mem_error),
        .stall_cycles       (stall_cycles),
        .flush_count        (flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic compute_expected();
        bit access, lu;
        access = mr | mw;
        lu = memread_ex && (rd_ex != 0) && ((rd_ex == rs1) || (rd_ex == rs2));
        e_pc = 1; e_ifid = 1; e_bub = 0; e_fl = 0; e_hold = 0; e_req = 0; e_frozen = 0;
        if (rst) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end else begin
            e_frozen = m_wait ? (!rdy && (m_waited < int'(T) - 1)) : (access && !rdy);
            e_req    = m_wait ? 1'b1 : access;
            if (e_frozen) begin
                e_pc = 0; e_ifid = 0; e_hold = 1;
            end else if (br) begin
                e_fl = 1;
            end else if (lu) begin
                e_pc = 0; e_ifid = 0; e_bub = 1;
            end
        end
    endtask

    task automatic check_all(input string ctx);
        compute_expected();
        chk({ctx, ".pc_write"},     32'(pc_write),     32'(e_pc));
        chk({ctx, ".if_id_write"},  32'(if_id_write),  32'(e_ifid));
        chk({ctx, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(e_bub));
        chk({ctx, ".if_id_flush"},  32'(if_id_flush),  32'(e_fl));
        chk({ctx, ".id_ex_flush"},  32'(id_ex_flush),  32'(e_fl));
        chk({ctx, ".pipe_hold"},    32'(pipe_hold),    32'(e_hold));
        chk({ctx, ".mem_req"},      32'(mem_req),      32'(e_req));
        chk({ctx, ".mem_error"},    32'(mem_error),    32'(rst ? 1'b0 : m_err));
        chk({ctx, ".stall_cycles"}, 32'(stall_cycles), PERF ? 32'(m_stall) : 32'd0);
        chk({ctx, ".flush_count"},  32'(flush_count),  PERF ? 32'(m_flush) : 32'd0);
    endtask

    task automatic model_advance();
        if (rst) begin
            model_reset();
        end else begin
            if (!e_pc && m_stall < CMAX) m_stall++;
            if (e_fl && m_flush < CMAX) m_flush++;
            if (m_wait) begin
                if (e_frozen) m_waited++;
                else begin
                    m_wait = 0;
                    if (!rdy) m_err = 1;
                end
            end else if (e_frozen) begin
                m_wait = 1;
                m_waited = 0;
            end
        end
    endtask

    // One clock cycle: check mid-cycle, advance the model on the edge.
    task automatic step(input string ctx);
        @(negedge clk);
        check_all(ctx);
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic set_in(input bit r, input bit mrd, input int rd, input int s1, input int s2,
                          input bit b, input bit m_r, input bit m_w, input bit ready);
        rst = r; memread_ex = mrd; rd_ex = 5'(rd); rs1 = 5'(s1); rs2 = 5'(s2);
        br = b; mr = m_r; mw = m_w; rdy = ready;
    endtask

    initial begin
        model_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        step("reset0");
        step("reset1");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle");

        // Load-use: one bubble, then normal
        set_in(0, 1, 5, 5, 0, 0, 0, 0, 0);
        step("loaduse");
        set_in(0, 0, 5, 6, 7, 0, 0, 0, 0);
        step("after_loaduse");
        set_in(0, 1, 6, 1, 6, 0, 0, 0, 0);
        step("loaduse_rs2");
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("rd0_no_stall");
        set_in(0, 1, 5, 5, 0, 1, 0, 0, 0);
        step("branch_over_loaduse");
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("branch");

        // Memory wait: 3 not-ready cycles then ready
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (3) step("memwait");
        rdy = 1;
        step("memwait_exit");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("after_memwait");

        // Zero-wait access
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("zero_wait");

        // Timeout with mem_ready held low
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (T + 1) step("timeout");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) step("err_sticky");

        // Branch arriving during a freeze is acted on at exit
        set_in(0, 0, 0, 0, 0, 1, 0, 1, 0);
        repeat (2) step("br_in_wait");
        rdy = 1;
        step("br_wait_exit");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(63) == 0), $urandom_range(1),
                   $urandom_range(3), $urandom_range(3), $urandom_range(3),
                   ($urandom_range(5) == 0), ($urandom_range(5) == 0),
                   ($urandom_range(7) == 0), ($urandom_range(2) == 0));
            step("rand");
        end

        // Asynchronous reset in the middle of a freeze
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 0);
        repeat (2) step("pre_async");
        #2 rst = 1;
        #1;
        chk("async.mem_req", 32'(mem_req), 32'd0);
        chk("async.pipe_hold", 32'(pipe_hold), 32'd0);
        chk("async.mem_error", 32'(mem_error), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        step("async_in_reset");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("after_async_run");
        set_in(0, 0, 0, 0, 0, 0, 1, 0, 1);
        step("after_async_access");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
